// File: rtl/vga_pkg.sv
// Shared VGA timing constants and scan-interface types for the 640x480@60 Hz display path.
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef logic [2:0]         rgb3_t;
  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate prescaler: one-clk p_tick every CLK_DIV system clocks.
module vga_pix_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_p_tick
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div_cnt;
  logic          r_p_tick;

  // p_tick is registered from the terminal count, so it is 0 in reset and
  // first rises exactly CLK_DIV clocks after release (constant 1 for CLK_DIV=1).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div_cnt <= '0;
      r_p_tick  <= 1'b0;
    end else begin
      r_p_tick  <= (r_div_cnt == DIV_LAST);
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
    end
  end

  assign o_p_tick = r_p_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan counters, sync decode and blanked colour register, advanced once per pixel tick.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] graph_rgb,
  output logic       p_tick,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [2:0] rgb
);

  import vga_pkg::*;

  // Totals must stay below 1024 to fit the 10-bit counters.
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic   w_p_tick;
  logic   w_h_wrap;
  logic   w_v_wrap;
  coord_t w_h_nxt;
  coord_t w_v_nxt;

  coord_t r_h_cnt;
  coord_t r_v_cnt;
  logic   r_video_on;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_frame_start;
  rgb3_t  r_rgb;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .i_clk    (clk),
    .i_reset  (reset),
    .o_p_tick (w_p_tick)
  );

  always_comb begin
    w_h_wrap = (r_h_cnt == H_LAST);
    w_v_wrap = (r_v_cnt == V_LAST);
    w_h_nxt  = r_h_cnt;
    w_v_nxt  = r_v_cnt;
    if (w_p_tick) begin
      if (w_h_wrap) begin
        w_h_nxt = '0;
        w_v_nxt = w_v_wrap ? '0 : r_v_cnt + 1'b1;
      end else begin
        w_h_nxt = r_h_cnt + 1'b1;
      end
    end
  end

  // Decode from the next counter values so the flags change on the same edge as pix_x/pix_y;
  // the colour register samples the current pixel, giving one pixel slot of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_video_on    <= 1'b1;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
      r_rgb         <= '0;
    end else begin
      r_h_cnt       <= w_h_nxt;
      r_v_cnt       <= w_v_nxt;
      r_video_on    <= (w_h_nxt < H_ACT_C) && (w_v_nxt < V_ACT_C);
      r_hsync       <= !((w_h_nxt >= HS_FIRST) && (w_h_nxt <= HS_LAST));
      r_vsync       <= !((w_v_nxt >= VS_FIRST) && (w_v_nxt <= VS_LAST));
      r_frame_start <= w_p_tick && w_h_wrap && w_v_wrap;
      if (w_p_tick) begin
        r_rgb <= r_video_on ? rgb3_t'(graph_rgb) : '0;
      end
    end
  end

  assign p_tick      = w_p_tick;
  assign video_on    = r_video_on;
  assign pix_x       = r_h_cnt;
  assign pix_y       = r_v_cnt;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;
  assign rgb         = r_rgb;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default, CLK_DIV=1 and a shrunken-timing instance against a closed-form model.
module tb_vga_sync_gen;

  typedef struct {
    int d;
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
  } tm_t;

  typedef struct packed {
    logic       p_tick;
    logic       frame_start;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] rgb;
  } ov_t;

  typedef struct {
    int         c;
    logic [9:0] x;
    logic [9:0] y;
    logic       vo;
    logic       hs;
    logic       vs;
    logic       pt;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [2:0] graph_rgb;

  logic       a_pt, a_vo, a_hs, a_vs, a_fs;
  logic [9:0] a_x, a_y;
  logic [2:0] a_rgb;
  logic       b_pt, b_vo, b_hs, b_vs, b_fs;
  logic [9:0] b_x, b_y;
  logic [2:0] b_rgb;
  logic       s_pt, s_vo, s_hs, s_vs, s_fs;
  logic [9:0] s_x, s_y;
  logic [2:0] s_rgb;

  ov_t act [3];
  assign act[0] = {a_pt, a_fs, a_vo, a_hs, a_vs, a_x, a_y, a_rgb};
  assign act[1] = {b_pt, b_fs, b_vo, b_hs, b_vs, b_x, b_y, b_rgb};
  assign act[2] = {s_pt, s_fs, s_vo, s_hs, s_vs, s_x, s_y, s_rgb};

  vga_sync_gen #(.CLK_DIV(4)) u_d4 (
    .clk(clk), .reset(reset), .graph_rgb(graph_rgb), .p_tick(a_pt), .video_on(a_vo),
    .pix_x(a_x), .pix_y(a_y), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs), .rgb(a_rgb)
  );

  vga_sync_gen #(.CLK_DIV(1)) u_d1 (
    .clk(clk), .reset(reset), .graph_rgb(graph_rgb), .p_tick(b_pt), .video_on(b_vo),
    .pix_x(b_x), .pix_y(b_y), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs), .rgb(b_rgb)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk(clk), .reset(reset), .graph_rgb(graph_rgb), .p_tick(s_pt), .video_on(s_vo),
    .pix_x(s_x), .pix_y(s_y), .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs), .rgb(s_rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err    = 0;
  int         c        = 0;
  tm_t        tm [3];
  logic [2:0] m_rgb [3];
  string      iname [3];
  bit         count_en = 1'b0;
  int         a_hs_low, b_hs_low, s_vs_low, s_fs_cnt, s_fs_first;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (clk %0d after reset)", nm, got, exp, c);
    end
  endtask

  // Pixel index n after c clocks since release; everything else follows by arithmetic.
  function automatic int n_of(tm_t t, int cc);
    return (cc >= 1) ? (cc - 1) / t.d : 0;
  endfunction

  function automatic bit vo_of(tm_t t, int n);
    int ht = t.ha + t.hf + t.hs + t.hb;
    int vt = t.va + t.vf + t.vs + t.vb;
    return ((n % ht) < t.ha) && (((n / ht) % vt) < t.va);
  endfunction

  function automatic ov_t model(tm_t t, int cc, logic [2:0] mr);
    ov_t o;
    int ht = t.ha + t.hf + t.hs + t.hb;
    int vt = t.va + t.vf + t.vs + t.vb;
    int n  = n_of(t, cc);
    int h  = n % ht;
    int v  = (n / ht) % vt;
    o.p_tick      = (cc >= 1) && (cc % t.d == 0);
    o.frame_start = (cc >= 2) && ((cc - 1) % t.d == 0) && (n % (ht * vt) == 0);
    o.video_on    = (h < t.ha) && (v < t.va);
    o.hsync       = !((h >= t.ha + t.hf) && (h < t.ha + t.hf + t.hs));
    o.vsync       = !((v >= t.va + t.vf) && (v < t.va + t.vf + t.vs));
    o.x           = 10'(h);
    o.y           = 10'(v);
    o.rgb         = mr;
    return o;
  endfunction

  task automatic step(input logic rst, input logic [2:0] g);
    reset     = rst;
    graph_rgb = g;
    @(posedge clk);
    if (rst) begin
      c = 0;
      for (int k = 0; k < 3; k++) m_rgb[k] = 3'b000;
    end else begin
      c++;
      for (int k = 0; k < 3; k++) begin
        if (c >= 2 && (c - 1) % tm[k].d == 0)
          m_rgb[k] = vo_of(tm[k], n_of(tm[k], c) - 1) ? g : 3'b000;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) chk(iname[k], act[k], model(tm[k], c, m_rgb[k]));
    if (count_en && !rst) begin
      if (c <= 3200 && a_pt && !a_hs) a_hs_low++;
      if (c <= 800 && b_pt && !b_hs) b_hs_low++;
      if (c <= 300 && s_pt && !s_vs) s_vs_low++;
      if (c <= 301 && s_fs) begin
        s_fs_cnt++;
        if (s_fs_first < 0) s_fs_first = c;
      end
    end
  endtask

  vec_t tbl [10];

  initial begin
    tm[0] = '{d: 4, ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33};
    tm[1] = '{d: 1, ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33};
    tm[2] = '{d: 2, ha: 8, hf: 2, hs: 3, hb: 2, va: 6, vf: 1, vs: 2, vb: 1};
    iname[0] = "d4"; iname[1] = "d1"; iname[2] = "small";
    for (int k = 0; k < 3; k++) m_rgb[k] = 3'b000;

    // {clk after release, x, y, video_on, hsync, vsync, p_tick} for the CLK_DIV=4 instance
    tbl[0] = '{c: 1,    x: 0,   y: 0, vo: 1, hs: 1, vs: 1, pt: 0};
    tbl[1] = '{c: 4,    x: 0,   y: 0, vo: 1, hs: 1, vs: 1, pt: 1};
    tbl[2] = '{c: 5,    x: 1,   y: 0, vo: 1, hs: 1, vs: 1, pt: 0};
    tbl[3] = '{c: 8,    x: 1,   y: 0, vo: 1, hs: 1, vs: 1, pt: 1};
    tbl[4] = '{c: 2561, x: 640, y: 0, vo: 0, hs: 1, vs: 1, pt: 0};
    tbl[5] = '{c: 2621, x: 655, y: 0, vo: 0, hs: 1, vs: 1, pt: 0};
    tbl[6] = '{c: 2625, x: 656, y: 0, vo: 0, hs: 0, vs: 1, pt: 0};
    tbl[7] = '{c: 3005, x: 751, y: 0, vo: 0, hs: 0, vs: 1, pt: 0};
    tbl[8] = '{c: 3009, x: 752, y: 0, vo: 0, hs: 1, vs: 1, pt: 0};
    tbl[9] = '{c: 3201, x: 0,   y: 1, vo: 1, hs: 1, vs: 1, pt: 0};

    a_hs_low = 0; b_hs_low = 0; s_vs_low = 0; s_fs_cnt = 0; s_fs_first = -1;

    step(1'b1, 3'b000);
    step(1'b1, 3'b000);
    count_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      while (c < tbl[i].c) step(1'b0, 3'($urandom_range(0, 7)));
      chk($sformatf("tbl[%0d]", i), {a_x, a_y, a_vo, a_hs, a_vs, a_pt},
          {tbl[i].x, tbl[i].y, tbl[i].vo, tbl[i].hs, tbl[i].vs, tbl[i].pt});
    end
    count_en = 1'b0;

    chk("d4_hsync_low_ticks", 32'(a_hs_low), 96);
    chk("d1_hsync_low_ticks", 32'(b_hs_low), 96);
    chk("small_vsync_low_ticks", 32'(s_vs_low), 30);
    chk("small_frame_start_cnt", 32'(s_fs_cnt), 1);
    chk("small_frame_start_clk", 32'(s_fs_first), 301);

    // Constant colour: blanking edges lag video_on by one pixel slot.
    for (int k = 0; k < 4000 && a_vo; k++) step(1'b0, 3'b101);
    chk("vo_fall_seen", 32'(a_vo), 0);
    chk("rgb_before_blank", 32'(a_rgb), 32'h5);
    for (int k = 0; k < 4; k++) step(1'b0, 3'b101);
    chk("rgb_after_blank", 32'(a_rgb), 0);
    for (int k = 0; k < 4000 && !a_vo; k++) step(1'b0, 3'b101);
    chk("vo_rise_seen", 32'(a_vo), 1);
    chk("rgb_before_active", 32'(a_rgb), 0);
    for (int k = 0; k < 4; k++) step(1'b0, 3'b101);
    chk("rgb_after_active", 32'(a_rgb), 32'h5);

    // Mid-line reset takes effect on the very next edge.
    for (int k = 0; k < 4000 && a_x != 10'd300; k++) step(1'b0, 3'($urandom_range(0, 7)));
    chk("reach_x300", 32'(a_x), 300);
    step(1'b1, 3'b111);
    chk("mid_reset_d4", {a_x, a_y, a_rgb, a_hs, a_vs, a_pt, a_fs}, {10'd0, 10'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    for (int k = 0; k < 4000; k++) step(1'b0, 3'($urandom_range(0, 7)));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA timing from the system clock and drives the `video_on`/`pix_x`/`pix_y` scan interface consumed by the pixel generators (display test pattern, later framebuffer reader). It also registers the 3-bit pixel colour returned by the generator and blanks it outside the active area. It sits between the board clock/reset and the VGA connector, one instance per display path.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; 100 MHz clock gives 25 MHz pixel rate. Must be ≥1.
- `H_ACTIVE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal timing in pixels.
- `V_ACTIVE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing in lines.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `graph_rgb`  in  3  colour from the pixel generator for the current `pix_x`/`pix_y`.
- `p_tick`  out  1  one-`clk` pulse marking each pixel slot.
- `video_on`  out  1  high while the counters are inside the active area.
- `pix_x`  out  10  horizontal counter, 0..799.
- `pix_y`  out  10  vertical counter, 0..524.
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `frame_start`  out  1  one-`clk` pulse on the tick where `pix_x`=0 and `pix_y`=0.
- `rgb`  out  3  registered, blanked colour to the connector.

## Operation
- Prescaler `div_cnt`, 0..CLK_DIV-1, wraps each CLK_DIV clocks. `p_tick`=1 when `div_cnt`=CLK_DIV-1. With CLK_DIV=1, `p_tick` is constantly 1.
- On `p_tick`, `h_cnt` increments. At H_TOTAL-1 (799) it wraps to 0 and `v_cnt` increments. `v_cnt` wraps from V_TOTAL-1 (524) to 0 on the same tick that `h_cnt` wraps.
- Counters hold between ticks.
- `video_on` = (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).
- `hsync`=0 for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
- `vsync`=0 for `v_cnt` in [490,491].
- `pix_x`=`h_cnt` and `pix_y`=`v_cnt`. `video_on`, `hsync` and `vsync` are registered, computed from the next counter values, so all five change on the same `clk` edge.
- `rgb` register: on `p_tick`, loads `video_on ? graph_rgb : 3'b000`. Otherwise it holds.
- Widths: counters are 10 bits; totals are computed from the parameters in the package and must be < 1024.

## Timing
- Reset values: `div_cnt`=0, `h_cnt`=`v_cnt`=0, `pix_x`=`pix_y`=0, `video_on`=1, `hsync`=`vsync`=1, `p_tick`=0, `frame_start`=0, `rgb`=0.
- After reset deasserts, the first `p_tick` occurs CLK_DIV clocks later.
- `frame_start` pulses when the counters return to (0,0), not directly out of reset.
- Reset asserted mid-frame takes priority over everything: on the next edge all state returns to reset values, with no partial line.
- Colour pipeline latency:
  - `graph_rgb` is sampled one `clk` before the counters advance.
  - `rgb` reflects the pixel at (`pix_x`,`pix_y`) for the following pixel slot.
  - `hsync`/`vsync` are not delayed. The one-`clk` skew is within VGA tolerance, and this is accepted.
- Line period: 800 ticks. Frame period: 420 000 ticks (1 680 000 clk at CLK_DIV=4).

## Structure
- Package `vga_pkg`:
  - the timing localparams (H_*/V_*, H_TOTAL=800, V_TOTAL=525, sync start/end);
  - the `rgb3_t` typedef (3-bit);
  - the `coord_t` typedef (10-bit).
- One natural sub-module: `vga_pix_tick`, the prescaler producing `p_tick`.
- Counters, sync decode and the colour register stay in the top.

## Test plan
- Reset release at CLK_DIV=4 -> first `p_tick` 4 clk later; `pix_x` increments every 4 clk; `hsync`=`vsync`=1 until `pix_x`=656.
- Run one line -> `hsync` low for exactly 96 ticks (`pix_x` 656..751). `video_on` falls at `pix_x`=640. `pix_y` increments on the 799→0 wrap.
- Run one full frame -> `vsync` low only on lines 490-491 (1600 ticks). `frame_start` pulses once, at 420 000 ticks. `video_on` is 0 for all of lines 480-524.
- Drive `graph_rgb`=3'b101 constant -> `rgb`=101 during active pixels and 000 during blanking, with transitions one pixel slot after `video_on` changes.
- Assert `reset` for one clk at `pix_x`=300, `pix_y`=200 -> next edge gives `pix_x`=`pix_y`=0, `rgb`=0, `hsync`=`vsync`=1. Timing then restarts cleanly.
- CLK_DIV=1 -> `p_tick` constantly high; line = 800 clk; all sync windows unchanged in pixel units.
